mac_seq_ctrl: RTL and testbench

Sequencer for the signed 16x16→32 MAC datapath (mac_unit): it runs one dot product per job. Each job loads a bias into the accumulator, streams N operand pairs through the MAC under a valid/ready handshake, and then presents the final accumulator value on a valid/ready result port. It sits between the operand source (memory/stream front end) and the mac_unit instance, owning all mac_unit control inputs.

---
 rtl/mac_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: per-job sequencer for the signed MAC datapath.
// Each job loads a bias into the accumulator, streams len operand pairs
// through mac_unit under valid/ready, then presents the accumulator on a
// valid/ready result port.
//
// state | meaning
// IDLE  | waiting for start, mac_unit untouched
// LOAD  | accumulator <= bias
// RUN   | accepting operand pairs, bubbles hold the accumulator
// DRAIN | last product has landed, capture mac_result
// OUT   | result presented until out_ready
module mac_seq_ctrl #(
    parameter int DW = 16,
    parameter int AW = 32,
    parameter int LW = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [LW-1:0]        len_i,
    input  logic signed [AW-1:0] bias_i,
    input  logic                 abort_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic signed [DW-1:0] in_x_i,
    input  logic signed [DW-1:0] in_y_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic signed [AW-1:0] out_result_o,
    output logic                 busy_o,
    output logic                 mac_en_o,
    output logic                 mac_acc_load_o,
    output logic signed [AW-1:0] mac_z_o,
    output logic signed [DW-1:0] mac_x_o,
    output logic signed [DW-1:0] mac_y_o,
    input  logic signed [AW-1:0] mac_result_i
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         cnt_q, cnt_d;
    logic signed [AW-1:0]  bias_q, bias_d;
    logic signed [AW-1:0]  result_q, result_d;

    // State, remaining-pair counter, latched bias and result register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bias_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bias_q   <= bias_d;
            result_q <= result_d;
        end
    end

    // Next-state logic and all mac_unit / handshake controls.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bias_d         = bias_q;
        result_d       = result_q;
        in_ready_o     = 1'b0;
        out_valid_o    = 1'b0;
        mac_en_o       = 1'b0;
        mac_acc_load_o = 1'b0;
        mac_z_o        = '0;
        mac_x_o        = '0;
        mac_y_o        = '0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cnt_d   = len_i;
                    bias_d  = bias_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                mac_en_o       = 1'b1;
                mac_acc_load_o = 1'b1;
                mac_z_o        = bias_q;
                state_d        = (cnt_q == '0) ? DRAIN : RUN;
            end
            RUN: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    mac_en_o = 1'b1;
                    mac_x_o  = in_x_i;
                    mac_y_o  = in_y_i;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == LW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                result_d = mac_result_i;
                state_d  = OUT;
            end
            OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over every transfer this cycle: nothing is consumed,
        // the accumulator is left alone and the last result is kept.
        if (abort_i) begin
            state_d        = IDLE;
            cnt_d          = cnt_q;
            bias_d         = bias_q;
            result_d       = result_q;
            in_ready_o     = 1'b0;
            mac_en_o       = 1'b0;
            mac_acc_load_o = 1'b0;
            mac_z_o        = '0;
            mac_x_o        = '0;
            mac_y_o        = '0;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign out_result_o = result_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed + randomized bench for mac_seq_ctrl with a behavioural mac_unit
// and a sum-of-products reference for each job's expected result.
module tb_mac_seq_ctrl;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int LW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [LW-1:0]        len;
    logic signed [AW-1:0] bias;
    logic                 abort;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_x, in_y;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] out_result;
    logic                 busy;
    logic                 mac_en, mac_acc_load;
    logic signed [AW-1:0] mac_z;
    logic signed [DW-1:0] mac_x, mac_y;
    logic signed [AW-1:0] mac_result;

    int n_checks = 0;
    int n_fail   = 0;
    int last_res = 0;
    logic signed [DW-1:0] px[256];
    logic signed [DW-1:0] py[256];

    always #5 clk = ~clk;

    mac_seq_ctrl #(.DW(DW), .AW(AW), .LW(LW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .bias_i(bias),
        .abort_i(abort), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_x_i(in_x), .in_y_i(in_y), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_result_o(out_result), .busy_o(busy),
        .mac_en_o(mac_en), .mac_acc_load_o(mac_acc_load), .mac_z_o(mac_z),
        .mac_x_o(mac_x), .mac_y_o(mac_y), .mac_result_i(mac_result)
    );

    // Behavioural mac_unit: load, multiply-accumulate with 32-bit wrap, hold.
    int acc = 0;
    always @(posedge clk) begin
        if (mac_en) acc <= mac_acc_load ? int'(mac_z) : acc + int'(mac_x) * int'(mac_y);
    end
    assign mac_result = acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int exp_res);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".in_ready"}, 32'(in_ready), 0);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk({tag, ".mac_en"}, 32'(mac_en), 0);
        chk({tag, ".mac_acc_load"}, 32'(mac_acc_load), 0);
        chk({tag, ".mac_z"}, mac_z, 0);
        chk({tag, ".mac_xy"}, {mac_x, mac_y}, 0);
        chk({tag, ".out_result"}, out_result, exp_res);
    endtask

    // One job: pairs come from px/py; bub<0 picks random bubbles per gap.
    task automatic run_job(input string nm, input int b, input int n, input int bub,
                           input int bp, input bit pulse_start);
        int expv;
        int k;
        expv = b;
        for (int i = 0; i < n; i++) expv += int'(px[i]) * int'(py[i]);

        @(negedge clk);
        start = 1'b1; len = n[LW-1:0]; bias = b;
        #1 chk({nm, ".idle_busy"}, 32'(busy), 0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({nm, ".load_busy"}, 32'(busy), 1);
        chk({nm, ".load_en"}, {30'd0, mac_en, mac_acc_load}, 3);
        chk({nm, ".load_z"}, mac_z, b);
        chk({nm, ".load_rdy"}, 32'(in_ready), 0);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            k = (i == 0) ? 0 : ((bub < 0) ? int'($urandom_range(0, 2)) : bub);
            repeat (k) begin
                in_valid = 1'b0; in_x = 16'($urandom); in_y = 16'($urandom);
                #1;
                chk({nm, ".bub_rdy"}, 32'(in_ready), 1);
                chk({nm, ".bub_en"}, 32'(mac_en), 0);
                chk({nm, ".bub_xy"}, {mac_x, mac_y}, 0);
                @(negedge clk);
            end
            in_valid = 1'b1; in_x = px[i]; in_y = py[i];
            #1;
            chk({nm, ".run_rdy"}, 32'(in_ready), 1);
            chk({nm, ".run_en"}, {30'd0, mac_en, mac_acc_load}, 2);
            chk({nm, ".run_xy"}, {mac_x, mac_y}, {px[i], py[i]});
            chk({nm, ".run_ov"}, 32'(out_valid), 0);
            @(negedge clk);
            in_valid = 1'b0;
        end
        in_valid = 1'b1; in_x = 16'($urandom); in_y = 16'($urandom);
        #1;
        chk({nm, ".drain_rdy"}, 32'(in_ready), 0);
        chk({nm, ".drain_en"}, 32'(mac_en), 0);
        chk({nm, ".drain_ov"}, 32'(out_valid), 0);
        chk({nm, ".drain_busy"}, 32'(busy), 1);
        @(negedge clk);
        for (int i = 0; i < bp; i++) begin
            out_ready = 1'b0;
            if (pulse_start && i == 1) begin
                start = 1'b1; bias = $urandom; len = 8'($urandom_range(1, 9));
            end
            #1;
            chk({nm, ".bp_ov"}, 32'(out_valid), 1);
            chk({nm, ".bp_res"}, out_result, expv);
            chk({nm, ".bp_rdy"}, 32'(in_ready), 0);
            chk({nm, ".bp_en"}, 32'(mac_en), 0);
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk({nm, ".out_ov"}, 32'(out_valid), 1);
        chk({nm, ".out_res"}, out_result, expv);
        chk({nm, ".out_busy"}, 32'(busy), 1);
        @(negedge clk);
        out_ready = 1'b0;
        #1 chk_idle({nm, ".after"}, expv);
        @(negedge clk);
        chk({nm, ".single_ov"}, 32'(out_valid), 0);
        chk({nm, ".single_busy"}, 32'(busy), 0);
        last_res = expv;
    endtask

    // Start a 3-pair job, feed one pair, then cut it with rst or abort.
    task automatic interrupt(input string nm, input bit use_rst);
        @(negedge clk);
        start = 1'b1; len = 8'd3; bias = $urandom;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_x = 16'sd9; in_y = 16'sd9;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({nm, ".mid_busy"}, 32'(busy), 1);
        if (use_rst) begin
            rst = 1'b1;
            #1 chk_idle({nm, ".rst"}, 0);
            @(negedge clk);
            rst = 1'b0;
            last_res = 0;
        end else begin
            abort = 1'b1; in_valid = 1'b1; start = 1'b1;
            #1;
            chk({nm, ".ab_rdy"}, 32'(in_ready), 0);
            chk({nm, ".ab_en"}, 32'(mac_en), 0);
            @(negedge clk);
            abort = 1'b0; in_valid = 1'b0; start = 1'b0;
        end
        #1 chk_idle({nm, ".idle"}, last_res);
        @(negedge clk);
        chk_idle({nm, ".idle2"}, last_res);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; len = '0; bias = '0; abort = 1'b0;
        in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset", 0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_reset", 0);

        px[0] = 16'sd10; py[0] = 16'sd3;
        run_job("j_bias50", 50, 1, 0, 0, 0);
        chk("j_bias50.value", last_res, 80);

        px[0] = -16'sd5; py[0] = 16'sd4; px[1] = -16'sd3; py[1] = 16'sd5;
        run_job("j_neg", 20, 2, 0, 0, 0);
        chk("j_neg.value", last_res, -15);
        px[0] = 16'sd7; py[0] = -16'sd6;
        run_job("j_next", 0, 1, 0, 0, 0);

        run_job("j_len0", -7, 0, 0, 0, 0);

        px[0] = 16'sd1; py[0] = 16'sd2; px[1] = 16'sd3; py[1] = 16'sd4;
        px[2] = 16'sd5; py[2] = 16'sd6;
        run_job("j_bubble", 0, 3, 2, 0, 0);
        run_job("j_nobubble", 0, 3, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin px[i] = 16'($urandom); py[i] = 16'($urandom); end
        run_job("j_backpressure", int'($urandom), 4, 0, 5, 1);

        interrupt("i_rst", 1'b1);
        px[0] = 16'sd2; py[0] = 16'sd2;
        run_job("j_after_rst", 1, 1, 0, 0, 0);
        interrupt("i_abort", 1'b0);
        run_job("j_after_abort", 1, 1, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin px[i] = 16'sh7fff; py[i] = 16'sh7fff; end
        run_job("j_wrap", 32'sh7fff_fff0, 4, 0, 0, 0);

        for (int j = 0; j < 8; j++) begin
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin px[i] = 16'($urandom); py[i] = 16'($urandom); end
            run_job("j_rand", int'($urandom), n, -1, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
